// File: rtl/sdf_pkg.sv
// ---------------------------------------------------------------------------
// sdf_pkg
// Shared definitions for the signed-distance scene evaluator:
//   SDF_WIDTH / SDF_FRAC : default fixed-point word and fraction widths
//   vec3                 : packed {x,y,z} coordinate triple
//   sdf_state_t          : evaluator FSM states
//   sat_signed()         : clamp a sign-extended 64-bit value into w bits
// ---------------------------------------------------------------------------
package sdf_pkg;

    localparam int SDF_WIDTH = 32;
    localparam int SDF_FRAC  = 16;

    typedef struct packed {
        logic [SDF_WIDTH-1:0] x;
        logic [SDF_WIDTH-1:0] y;
        logic [SDF_WIDTH-1:0] z;
    } vec3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SQUARE = 3'd1,
        ST_ROOT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } sdf_state_t;

    // Clamp v into the signed range of a w-bit word (valid for w <= 62).
    // Result is returned sign-extended; callers keep the low w bits.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] v,
        input int unsigned        w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/sdf_scene_min_isqrt_seq.sv
// ---------------------------------------------------------------------------
// isqrt_seq
// Sequential restoring integer square root, one root bit per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load radicand (the first bit is resolved on this edge)
//   radicand   : 2*WIDTH-bit unsigned operand
//   root       : WIDTH-bit floor(sqrt(radicand)), valid while done is high
//              and held until the next start
//   done       : one-cycle pulse, high exactly WIDTH cycles after start
// WIDTH must be at least 2.
// ---------------------------------------------------------------------------
module isqrt_seq #(
    parameter int WIDTH = sdf_pkg::SDF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   radicand,
    output logic [WIDTH-1:0]     root,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_rad;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_root;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [2*WIDTH-1:0] w_src_rad;
    logic [WIDTH-1:0]   w_src_rem;
    logic [WIDTH-1:0]   w_src_root;
    logic [WIDTH+1:0]   w_rem_sh;
    logic [WIDTH+1:0]   w_trial;
    logic [WIDTH+1:0]   w_rem_next;
    logic               w_ge;
    logic               w_unused_rem;

    // On the start edge the iteration runs straight from the inputs, so the
    // remaining WIDTH-1 iterations finish in time for done after WIDTH cycles.
    always_comb begin
        w_src_rad  = start ? radicand : r_rad;
        w_src_rem  = start ? '0 : r_rem;
        w_src_root = start ? '0 : r_root;
        // Before any iteration the partial root has at most WIDTH-1 bits, so
        // the remainder (<= 2*root) fits in WIDTH bits before shifting.
        w_rem_sh   = {w_src_rem, w_src_rad[2*WIDTH-1 -: 2]};
        w_trial    = {w_src_root, 2'b01};
        w_ge       = (w_rem_sh >= w_trial);
        w_rem_next = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    end

    // Final remainder may need WIDTH+1 bits but is never reused.
    assign w_unused_rem = ^w_rem_next[WIDTH+1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start || r_busy) begin
                r_rad  <= {w_src_rad[2*WIDTH-3:0], 2'b00};
                r_rem  <= w_rem_next[WIDTH-1:0];
                r_root <= {w_src_root[WIDTH-2:0], w_ge};
            end
            if (start) begin
                r_busy <= 1'b1;
                r_cnt  <= CW'(WIDTH - 1);
            end else if (r_busy) begin
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign root = r_root;
    assign done = r_done;

endmodule

// File: rtl/sdf_scene_min.sv
// ---------------------------------------------------------------------------
// sdf_scene_min
// Minimum signed distance from a query point to a table of spheres.
// One query per handshake; spheres are evaluated one at a time through a
// shared sequential square root, NUM_SPHERES*(WIDTH+2) cycles per query.
//   clk, rst_n            : clock, synchronous active-low reset
//   cfg_we/cfg_idx/...    : sphere table write port (accepted only in IDLE)
//   cfg_ready             : table writes accepted this cycle
//   in_valid/in_ready/in_p: query point handshake ({x,y,z}, signed Q.FRAC)
//   out_valid/out_ready   : result handshake
//   out_dist              : signed minimum distance (0x7FF..F if none)
//   out_id                : index of nearest enabled sphere (lowest on tie)
//   out_none              : no sphere was enabled
// ---------------------------------------------------------------------------
module sdf_scene_min
    import sdf_pkg::*;
#(
    parameter int WIDTH       = SDF_WIDTH,
    parameter int FRAC        = SDF_FRAC,
    parameter int NUM_SPHERES = 4,
    localparam int IDW        = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [IDW-1:0]       cfg_idx,
    input  logic [3*WIDTH-1:0]   cfg_center,
    input  logic [WIDTH-1:0]     cfg_radius,
    input  logic                 cfg_en,
    output logic                 cfg_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3*WIDTH-1:0]   in_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_dist,
    output logic [IDW-1:0]       out_id,
    output logic                 out_none
);

    localparam logic [WIDTH-1:0] DIST_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    sdf_state_t r_state;
    sdf_state_t w_state_next;

    // Sphere table
    logic [3*WIDTH-1:0] r_center [NUM_SPHERES];
    logic [WIDTH-1:0]   r_radius [NUM_SPHERES];
    logic               r_en     [NUM_SPHERES];

    // Query state
    logic [3*WIDTH-1:0] r_p;
    logic [IDW-1:0]     r_idx;
    logic [WIDTH-1:0]   r_best;
    logic [IDW-1:0]     r_best_id;
    logic               r_none;

    logic [3*WIDTH-1:0]    w_cur_center;
    logic [WIDTH-1:0]      w_cur_radius;
    logic                  w_cur_en;
    logic signed [WIDTH:0] w_d  [3];
    logic [2*WIDTH+1:0]    w_sq [3];
    logic [2*WIDTH+2:0]    w_s_full;
    logic [2*WIDTH-1:0]    w_s_sat;
    logic [WIDTH-1:0]      w_root;
    logic                  w_sq_done;
    logic                  w_sq_start;
    logic signed [WIDTH+1:0] w_dist_full;
    logic signed [63:0]    w_dist_sat64;
    logic [WIDTH-1:0]      w_dist;
    logic                  w_better;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_idle;
    logic                  w_unused_bits;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_accept     = w_idle && in_valid;
    assign w_cur_center = r_center[r_idx];
    assign w_cur_radius = r_radius[r_idx];
    assign w_cur_en     = r_en[r_idx];
    assign w_last       = (r_idx == IDW'(NUM_SPHERES - 1));

    // Per-axis difference and square. The difference needs WIDTH+1 bits so
    // opposite-extreme coordinates cannot wrap; squaring the sign-extended
    // value keeps the low 2*WIDTH+2 bits exact for either sign.
    for (genvar gi = 0; gi < 3; gi++) begin : g_axis
        logic [WIDTH-1:0]   w_p_ax;
        logic [WIDTH-1:0]   w_c_ax;
        logic [2*WIDTH+1:0] w_d_ext;
        assign w_p_ax   = r_p[gi*WIDTH +: WIDTH];
        assign w_c_ax   = w_cur_center[gi*WIDTH +: WIDTH];
        assign w_d[gi]  = $signed({w_p_ax[WIDTH-1], w_p_ax})
                        - $signed({w_c_ax[WIDTH-1], w_c_ax});
        assign w_d_ext  = {{(WIDTH+1){w_d[gi][WIDTH]}}, w_d[gi]};
        assign w_sq[gi] = w_d_ext * w_d_ext;
    end

    assign w_s_full = {1'b0, w_sq[0]} + {1'b0, w_sq[1]} + {1'b0, w_sq[2]};
    assign w_s_sat  = (|w_s_full[2*WIDTH+2:2*WIDTH]) ? '1 : w_s_full[2*WIDTH-1:0];

    assign w_sq_start = (r_state == ST_SQUARE);

    isqrt_seq #(
        .WIDTH (WIDTH)
    ) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_sq_start),
        .radicand (w_s_sat),
        .root     (w_root),
        .done     (w_sq_done)
    );

    // sqrt of a Q.2FRAC radicand is directly the Q.FRAC length.
    assign w_dist_full  = $signed({2'b00, w_root}) - $signed({2'b00, w_cur_radius});
    assign w_dist_sat64 = sat_signed($signed({{(64-WIDTH-2){w_dist_full[WIDTH+1]}}, w_dist_full}),
                                     WIDTH);
    assign w_dist       = w_dist_sat64[WIDTH-1:0];
    // Strict less-than keeps the earlier (lower) index on ties.
    assign w_better     = w_cur_en && (r_none || ($signed(w_dist) < $signed(r_best)));

    assign w_unused_bits = ^{w_dist_sat64[63:WIDTH], 32'(FRAC)};

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (in_valid) w_state_next = ST_SQUARE;
            ST_SQUARE: w_state_next = ST_ROOT;
            ST_ROOT:   if (w_sq_done) w_state_next = ST_UPDATE;
            ST_UPDATE: w_state_next = w_last ? ST_DONE : ST_SQUARE;
            ST_DONE:   if (out_ready) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- sphere table ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPHERES; i++) begin
                r_center[i] <= '0;
                r_radius[i] <= '0;
                r_en[i]     <= 1'b0;
            end
        end else if (w_idle && cfg_we) begin
            // Indices with no matching entry fall through and are dropped.
            for (int i = 0; i < NUM_SPHERES; i++) begin
                if (cfg_idx == IDW'(i)) begin
                    r_center[i] <= cfg_center;
                    r_radius[i] <= cfg_radius;
                    r_en[i]     <= cfg_en;
                end
            end
        end
    end

    // ---------------- query datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p       <= '0;
            r_idx     <= '0;
            r_best    <= '0;
            r_best_id <= '0;
            r_none    <= 1'b0;
        end else if (w_accept) begin
            r_p       <= in_p;
            r_idx     <= '0;
            r_best    <= DIST_MAX;
            r_best_id <= '0;
            r_none    <= 1'b1;
        end else if (r_state == ST_UPDATE) begin
            if (w_better) begin
                r_best    <= w_dist;
                r_best_id <= r_idx;
                r_none    <= 1'b0;
            end
            if (!w_last)
                r_idx <= r_idx + IDW'(1);
        end
    end

    assign in_ready  = w_idle;
    assign cfg_ready = w_idle;
    assign out_valid = (r_state == ST_DONE);
    assign out_dist  = r_best;
    assign out_id    = r_best_id;
    assign out_none  = r_none;

endmodule

// File: tb/tb_sdf_scene_min.sv
// ---------------------------------------------------------------------------
// tb_sdf_scene_min
// Directed bench for sdf_scene_min with default parameters (Q16.16, 4 spheres).
// ---------------------------------------------------------------------------
module tb_sdf_scene_min;
    import sdf_pkg::*;

    localparam int          LAT   = 4 * (32 + 2);
    localparam logic [31:0] ONE   = 32'h0001_0000;
    localparam logic [31:0] TWO   = 32'h0002_0000;
    localparam logic [31:0] THREE = 32'h0003_0000;
    localparam logic [31:0] FOUR  = 32'h0004_0000;
    localparam logic [31:0] FIVE  = 32'h0005_0000;
    localparam logic [31:0] HALF  = 32'h0000_8000;
    localparam logic [31:0] DMAX  = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [95:0] cfg_center;
    logic [31:0] cfg_radius;
    logic        cfg_en;
    logic        cfg_ready;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_p;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_dist;
    logic [1:0]  out_id;
    logic        out_none;

    int tests = 0;
    int fails = 0;

    sdf_scene_min dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_center (cfg_center),
        .cfg_radius (cfg_radius),
        .cfg_en     (cfg_en),
        .cfg_ready  (cfg_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p       (in_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dist   (out_dist),
        .out_id     (out_id),
        .out_none   (out_none)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [31:0] cx, input logic [31:0] cy,
                             input logic [31:0] cz, input logic [31:0] r, input logic en);
        vec3 v;
        v = '{x: cx, y: cy, z: cz};
        cfg_we     = 1'b1;
        cfg_idx    = idx;
        cfg_center = v;
        cfg_radius = r;
        cfg_en     = en;
        @(posedge clk); #1;
        cfg_we     = 1'b0;
    endtask

    task automatic start_query(input string tag, input logic [31:0] px, input logic [31:0] py,
                               input logic [31:0] pz);
        vec3 v;
        v = '{x: px, y: py, z: pz};
        check({tag, "_in_ready_idle"}, in_ready, 1'b1);
        in_valid = 1'b1;
        in_p     = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    // already: cycles elapsed since the accepting edge when called.
    task automatic finish_query(input string tag, input int already, input int hold,
                                input logic [31:0] exp_dist, input logic [1:0] exp_id,
                                input logic exp_none);
        int n;
        logic [31:0] held;
        n = already;
        while (!out_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, LAT);
        check({tag, "_dist"}, out_dist, exp_dist);
        check({tag, "_id"}, out_id, exp_id);
        check({tag, "_none"}, out_none, exp_none);
        $display("[TB] query %s dist=0x%08h id=%0d none=%0d latency=%0d",
                 tag, out_dist, out_id, out_none, n);
        held = out_dist;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_dist"}, out_dist, held);
            check({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_released_valid"}, out_valid, 1'b0);
        check({tag, "_released_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_idx    = '0;
        cfg_center = '0;
        cfg_radius = '0;
        cfg_en     = 1'b0;
        in_valid   = 1'b0;
        in_p       = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_dist", out_dist, 32'h0);
        check("rst_out_id", out_id, 2'd0);
        check("rst_out_none", out_none, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_cfg_ready", cfg_ready, 1'b1);

        // Single sphere at z=5, r=1: distance 4
        cfg_write(2'd0, 32'h0, 32'h0, FIVE, ONE, 1'b1);
        start_query("single", 32'h0, 32'h0, 32'h0);
        finish_query("single", 0, 0, FOUR, 2'd0, 1'b0);

        // Sphere 2 at (3,4,0), r=1: also 4, lower index wins the tie
        cfg_write(2'd2, THREE, FOUR, 32'h0, ONE, 1'b1);
        start_query("tie", 32'h0, 32'h0, 32'h0);
        finish_query("tie", 0, 0, FOUR, 2'd0, 1'b0);

        // Disable sphere 0: sphere 2 remains
        cfg_write(2'd0, 32'h0, 32'h0, FIVE, ONE, 1'b0);
        start_query("s0_off", 32'h0, 32'h0, 32'h0);
        finish_query("s0_off", 0, 0, FOUR, 2'd2, 1'b0);

        // Sphere 2 radius 2: 5-2 = 3
        cfg_write(2'd2, THREE, FOUR, 32'h0, TWO, 1'b1);
        start_query("r2", 32'h0, 32'h0, 32'h0);
        finish_query("r2", 0, 0, THREE, 2'd2, 1'b0);

        // Nothing enabled
        cfg_write(2'd2, THREE, FOUR, 32'h0, TWO, 1'b0);
        start_query("none", 32'h0, 32'h0, 32'h0);
        finish_query("none", 0, 0, DMAX, 2'd0, 1'b1);

        // Table write in the accepting cycle is used by that query: inside, -0.5
        cfg_we     = 1'b1;
        cfg_idx    = 2'd1;
        cfg_center = {ONE, ONE, ONE};
        cfg_radius = HALF;
        cfg_en     = 1'b1;
        start_query("same_cycle_cfg", ONE, ONE, ONE);
        finish_query("same_cycle_cfg", 0, 0, 32'hFFFF_8000, 2'd1, 1'b0);

        // Busy: in_valid and cfg_we are ignored
        start_query("busy", ONE, ONE, ONE);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("busy_in_ready", in_ready, 1'b0);
        check("busy_cfg_ready", cfg_ready, 1'b0);
        cfg_we     = 1'b1;
        cfg_idx    = 2'd1;
        cfg_center = {ONE, ONE, ONE};
        cfg_radius = HALF;
        cfg_en     = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        finish_query("busy", 6, 0, 32'hFFFF_8000, 2'd1, 1'b0);
        start_query("after_drop", ONE, ONE, ONE);
        finish_query("after_drop", 0, 0, 32'hFFFF_8000, 2'd1, 1'b0);

        // Saturation, with a 20-cycle stall in DONE and in_valid held high
        cfg_write(2'd1, ONE, ONE, ONE, HALF, 1'b0);
        cfg_write(2'd0, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 1'b1);
        start_query("saturate", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        in_valid = 1'b1;
        finish_query("saturate", 0, 20, DMAX, 2'd0, 1'b0);
        in_valid = 1'b0;

        // Reset mid-ROOT aborts and clears the table
        cfg_write(2'd1, ONE, ONE, ONE, HALF, 1'b1);
        start_query("abort", 32'h0, 32'h0, 32'h0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("abort_busy", in_ready, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_dist", out_dist, 32'h0);
        check("abort_out_none", out_none, 1'b0);
        repeat (LAT + 4) begin
            @(posedge clk); #1;
        end
        check("abort_no_partial", out_valid, 1'b0);
        start_query("cleared", 32'h0, 32'h0, 32'h0);
        finish_query("cleared", 0, 0, DMAX, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
